id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core, with integrated load-use hazard detection and a stall-cycle counter.
- Captures decoded operands and control from ID each cycle and presents them to EX.
- Its ex_rs1/ex_rs2/ex_rd fields feed the EX-stage forwarding unit directly.
- Generates the IF/ID stall, inserts bubbles, and honours flush from branch resolution.

---
 rtl/core_pkg.sv | 27 ++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage RISC-V core: ALU op classes, default widths
// and the packed control bundle that travels down the pipeline.
package core_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        ALUOP_LDST  = 2'b00,
        ALUOP_BR    = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ITYPE = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   branch;
        logic   alusrc;
        aluop_e aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: an ID instruction reads the register
// that a load currently in EX has not yet produced. rd=0 never creates a hazard.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    output logic              hz
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_use_rs1 && (ex_rd == id_rs1);
    assign rs2_match = id_use_rs2 && (ex_rd == id_rs2);

    assign hz = ex_valid && ex_memread && (ex_rd != '0) && id_valid && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation and a saturating
// stall-cycle counter. Priority per edge: flush, hold, stall bubble, capture.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [3:0]        id_funct,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              id_branch,
    input  logic              id_alusrc,
    input  logic [1:0]        id_aluop,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [XLEN-1:0]   ex_rdata1,
    output logic [XLEN-1:0]   ex_rdata2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [3:0]        ex_funct,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_branch,
    output logic              ex_alusrc,
    output logic [1:0]        ex_aluop,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_count
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  hz;

    // An invalid ID slot carries no side effects even though its datapath passes.
    always_comb begin
        id_ctrl = CTRL_BUBBLE;
        if (id_valid) begin
            id_ctrl.regwrite = id_regwrite;
            id_ctrl.memread  = id_memread;
            id_ctrl.memwrite = id_memwrite;
            id_ctrl.memtoreg = id_memtoreg;
            id_ctrl.branch   = id_branch;
            id_ctrl.alusrc   = id_alusrc;
            id_ctrl.aluop    = aluop_e'(id_aluop);
        end
    end

    load_use_detect #(.REG_AW(REG_AW)) u_detect (
        .ex_valid   (ex_valid),
        .ex_memread (ex_ctrl.memread),
        .ex_rd      (ex_rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .hz         (hz)
    );

    assign stall_o = hz && !flush && !hold;

    // Bubble, reset and flush all produce the same all-zero contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || (!hold && stall_o) || flush) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_rd     <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_funct  <= '0;
            ex_ctrl   <= CTRL_BUBBLE;
        end else if (!hold) begin
            ex_valid  <= id_valid;
            ex_pc     <= id_pc;
            ex_rs1    <= id_rs1;
            ex_rs2    <= id_rs2;
            ex_rd     <= id_rd;
            ex_rdata1 <= id_rdata1;
            ex_rdata2 <= id_rdata2;
            ex_imm    <= id_imm;
            ex_funct  <= id_funct;
            ex_ctrl   <= id_ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_o && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_memread  = ex_ctrl.memread;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_memtoreg = ex_ctrl.memtoreg;
    assign ex_branch   = ex_ctrl.branch;
    assign ex_alusrc   = ex_ctrl.alusrc;
    assign ex_aluop    = ex_ctrl.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (stall counter narrowed to 4 bits): each step
// queues the hand-written EX contents, stall and count expected after the edge.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] rdata1;
        logic [63:0] rdata2;
        logic [63:0] imm;
        logic [3:0]  funct;
        logic [7:0]  ctl;   // {regwrite, memread, memwrite, memtoreg, branch, alusrc, aluop}
    } ex_t;

    typedef struct packed {
        int   tag;
        ex_t  ex;
        logic stall;
        logic [3:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        id_valid, id_use_rs1, id_use_rs2;
    logic [63:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch, id_alusrc;
    logic [1:0]  id_aluop;
    logic        flush, hold;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_alusrc;
    logic [1:0]  ex_aluop;
    logic        stall_o;
    logic [3:0]  stall_count;

    id_ex_stage #(.XLEN(64), .REG_AW(5), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_funct(id_funct),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_branch(id_branch), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
        .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_funct(ex_funct),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .stall_o(stall_o), .stall_count(stall_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         step_no = 0;
    logic [3:0] exp_cnt = 4'd0;
    logic       stall_pre;
    ex_t        act;

    always @(posedge clk) stall_pre <= stall_o;

    always_comb begin
        act.valid  = ex_valid;
        act.pc     = ex_pc;
        act.rs1    = ex_rs1;
        act.rs2    = ex_rs2;
        act.rd     = ex_rd;
        act.rdata1 = ex_rdata1;
        act.rdata2 = ex_rdata2;
        act.imm    = ex_imm;
        act.funct  = ex_funct;
        act.ctl    = {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_alusrc, ex_aluop};
    end

    task automatic check_ex(input string name, input int tag, input ex_t a, input ex_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, tag, a, e);
        end
    endtask

    task automatic check_val(input string name, input int tag, input logic [3:0] a, input logic [3:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, tag, a, e);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_ex("ex_contents", e.tag, act, e.ex);
                check_val("stall_o", e.tag, {3'b0, stall_pre}, {3'b0, e.stall});
                check_val("stall_count", e.tag, stall_count, e.cnt);
            end
        end
    end

    // ---------------- driver ----------------
    function automatic ex_t mk(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [63:0] r1, input logic [63:0] r2,
                               input logic [63:0] imm, input logic [3:0] funct, input logic [7:0] ctl);
        ex_t t;
        t.valid = 1'b1; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.rdata1 = r1; t.rdata2 = r2; t.imm = imm; t.funct = funct; t.ctl = ctl;
        return t;
    endfunction

    task automatic drive(input ex_t ins, input logic u1, input logic u2, input logic fl, input logic hd);
        id_valid = ins.valid; id_pc = ins.pc; id_rs1 = ins.rs1; id_rs2 = ins.rs2; id_rd = ins.rd;
        id_rdata1 = ins.rdata1; id_rdata2 = ins.rdata2; id_imm = ins.imm; id_funct = ins.funct;
        {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch, id_alusrc, id_aluop} = ins.ctl;
        id_use_rs1 = u1; id_use_rs2 = u2; flush = fl; hold = hd;
    endtask

    task automatic step(input ex_t ins, input logic u1, input logic u2, input logic fl, input logic hd,
                        input ex_t exp_ex, input logic exp_stall);
        exp_t e;
        @(negedge clk);
        drive(ins, u1, u2, fl, hd);
        if (exp_stall && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        #1;
        step_no++;
        e.tag = step_no; e.ex = exp_ex; e.stall = exp_stall; e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    localparam logic [7:0] CTL_LD    = 8'b1101_0100;
    localparam logic [7:0] CTL_RTYPE = 8'b1000_0010;
    localparam logic [7:0] CTL_ITYPE = 8'b1000_0111;

    ex_t bub, ld5, add6, ld0, read0, nouse, alu5, inv6, ld7, add8;

    initial begin
        bub   = '0;
        ld5   = mk(64'h100, 5'd2, 5'd0, 5'd5, 64'h1000, 64'h0,    64'd8,  4'h3, CTL_LD);
        add6  = mk(64'h104, 5'd5, 5'd7, 5'd6, 64'hAAAA, 64'h5555, 64'd0,  4'h0, CTL_RTYPE);
        ld0   = mk(64'h108, 5'd2, 5'd0, 5'd0, 64'h1000, 64'h0,    64'd0,  4'h3, CTL_LD);
        read0 = mk(64'h10C, 5'd0, 5'd0, 5'd8, 64'h0,    64'h0,    64'd0,  4'h0, CTL_RTYPE);
        nouse = mk(64'h114, 5'd3, 5'd5, 5'd9, 64'h77,   64'h99,   64'd5,  4'h0, CTL_ITYPE);
        alu5  = mk(64'h118, 5'd1, 5'd1, 5'd5, 64'h10,   64'h10,   64'd1,  4'h0, CTL_ITYPE);
        ld7   = mk(64'h120, 5'd5, 5'd0, 5'd7, 64'h2000, 64'h0,    64'd16, 4'h3, CTL_LD);
        add8  = mk(64'h124, 5'd7, 5'd0, 5'd8, 64'h33,   64'h0,    64'd0,  4'h0, CTL_RTYPE);
        inv6  = add6; inv6.valid = 1'b0;
        // Invalid ID slot: datapath passes, every control bit dropped.
        begin
            ex_t t;
            t = add6; t.valid = 1'b0; t.ctl = 8'h00;
            read0.valid = 1'b1;
            nouse.valid = 1'b1;
            add8.valid = 1'b1;
            bub.valid = 1'b0;
            inv6 = add6; inv6.valid = 1'b0;
            alu5.valid = 1'b1;
            ld7.valid = 1'b1;
            ld0.valid = 1'b1;
            ld5.valid = 1'b1;
            add6.valid = 1'b1;
            t.valid = 1'b0;
            // t is the expected EX image for inv6
            reset = 1'b1;
            drive(bub, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            check_ex("reset_ex", 0, act, bub);
            check_val("reset_cnt", 0, stall_count, 4'd0);
            repeat (2) @(negedge clk);
            reset = 1'b0;
            #1;
            check_ex("post_reset_ex", 0, act, bub);

            // load-use on rs1: one bubble, then the add enters EX
            step(ld5,  1'b1, 1'b0, 1'b0, 1'b0, ld5,  1'b0);
            step(add6, 1'b1, 1'b1, 1'b0, 1'b0, bub,  1'b1);
            step(add6, 1'b1, 1'b1, 1'b0, 1'b0, add6, 1'b0);
            // no false hazards: rd=0 load, unused rs2, non-load producer
            step(ld0,   1'b1, 1'b0, 1'b0, 1'b0, ld0,   1'b0);
            step(read0, 1'b1, 1'b1, 1'b0, 1'b0, read0, 1'b0);
            step(ld5,   1'b1, 1'b0, 1'b0, 1'b0, ld5,   1'b0);
            step(nouse, 1'b1, 1'b0, 1'b0, 1'b0, nouse, 1'b0);
            step(alu5,  1'b1, 1'b0, 1'b0, 1'b0, alu5,  1'b0);
            step(add6,  1'b1, 1'b1, 1'b0, 1'b0, add6,  1'b0);
            // flush beats hold and hazard
            step(ld5,  1'b1, 1'b0, 1'b0, 1'b0, ld5, 1'b0);
            step(add6, 1'b1, 1'b1, 1'b1, 1'b1, bub, 1'b0);
            // plain flush
            step(ld5,  1'b1, 1'b0, 1'b1, 1'b0, bub, 1'b0);
            // hold for three cycles with changing ID, then release
            step(alu5,  1'b1, 1'b0, 1'b0, 1'b0, alu5,  1'b0);
            step(ld5,   1'b1, 1'b0, 1'b0, 1'b1, alu5,  1'b0);
            step(add6,  1'b1, 1'b1, 1'b0, 1'b1, alu5,  1'b0);
            step(read0, 1'b1, 1'b1, 1'b0, 1'b1, alu5,  1'b0);
            step(nouse, 1'b1, 1'b0, 1'b0, 1'b0, nouse, 1'b0);
            // hold masks a pending hazard; the stall fires once hold drops
            step(ld5,  1'b1, 1'b0, 1'b0, 1'b0, ld5,  1'b0);
            step(add6, 1'b1, 1'b1, 1'b0, 1'b1, ld5,  1'b0);
            step(add6, 1'b1, 1'b1, 1'b0, 1'b0, bub,  1'b1);
            step(add6, 1'b1, 1'b1, 1'b0, 1'b0, add6, 1'b0);
            // invalid ID slot drops control
            step(inv6, 1'b1, 1'b1, 1'b0, 1'b0, t, 1'b0);
            // dependent load chain: one bubble per pair
            step(ld5,  1'b1, 1'b0, 1'b0, 1'b0, ld5,  1'b0);
            step(ld7,  1'b1, 1'b0, 1'b0, 1'b0, bub,  1'b1);
            step(ld7,  1'b1, 1'b0, 1'b0, 1'b0, ld7,  1'b0);
            step(add8, 1'b1, 1'b1, 1'b0, 1'b0, bub,  1'b1);
            step(add8, 1'b1, 1'b1, 1'b0, 1'b0, add8, 1'b0);
        end

        // 20 more stalls drive the 4-bit counter into saturation at 15
        for (int i = 0; i < 20; i++) begin
            step(ld5,  1'b1, 1'b0, 1'b0, 1'b0, ld5, 1'b0);
            step(add6, 1'b1, 1'b1, 1'b0, 1'b0, bub, 1'b1);
        end

        // reset asserted while a load sits in EX and a stall is pending
        step(ld5, 1'b1, 1'b0, 1'b0, 1'b0, ld5, 1'b0);
        @(negedge clk);
        drive(add6, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("pre_reset_stall", 99, {3'b0, stall_o}, 4'd1);
        check_val("pre_reset_cnt", 99, stall_count, 4'd15);
        reset = 1'b1;
        #1;
        check_ex("async_reset_ex", 99, act, bub);
        check_val("async_reset_stall", 99, {3'b0, stall_o}, 4'd0);
        check_val("async_reset_cnt", 99, stall_count, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
